path_replay: RTL and testbench

- Downstream consumer of the maze path-search stage.
- After the search asserts done, this block drains the 2-bit direction stack the search built. The stack is LIFO, so it pops in reverse order.
- It buffers the moves, then replays them start-to-destination as a valid/ready stream of moves with absolute row/column coordinates.
- Sits between the direction stack and the move display/output logic.

---
 rtl/path_replay_if.sv | 24 ++
 rtl/path_replay.sv | 178 +++++++++++++++++
 tb/tb_path_replay.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/path_replay_if.sv
// Direction-stack and move-stream signals of path_replay.
// master: the replay block (pops the stack, drives the move stream).
// slave:  the surrounding logic (stack model/FIFO, move consumer).
interface path_replay_if;
    logic       stk_empty;
    logic [1:0] stk_dout;
    logic       stk_pop;
    logic       mv_valid;
    logic       mv_ready;
    logic [1:0] mv_dir;
    logic [3:0] mv_row;
    logic [3:0] mv_col;
    logic       mv_last;

    modport master (
        input  stk_empty, stk_dout, mv_ready,
        output stk_pop, mv_valid, mv_dir, mv_row, mv_col, mv_last
    );

    modport slave (
        output stk_empty, stk_dout, mv_ready,
        input  stk_pop, mv_valid, mv_dir, mv_row, mv_col, mv_last
    );
endinterface

// File: rtl/path_replay.sv
// path_replay: drains the LIFO direction stack left by the maze search into
// a local buffer, then replays the moves start-to-destination as a
// valid/ready stream carrying absolute {row,col} coordinates from (0,0).
// Optional build macro COORD_CHECK_EN: off-grid moves saturate at the edge
// and set err, and a non-empty path not ending at DEST_ADDR sets err.
// Without it coordinates wrap modulo 16 and only buffer overflow sets err.
module path_replay #(
    parameter int MAX_LEN   = 256,
    parameter int LEN_W     = 9,
    parameter int DEST_ADDR = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    path_replay_if.master        bus,
    output logic [LEN_W-1:0]     path_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_EMIT,
        S_FIN
    } state_t;

    localparam int               IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] FULL  = LEN_W'(MAX_LEN);

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] r_path_len;
    logic [IDX_W-1:0] r_index;
    logic [3:0]       r_row;
    logic [3:0]       r_col;
    logic             r_err;
    logic [1:0]       r_buf [MAX_LEN];

    logic             w_full;
    logic             w_pop;
    logic             w_emit;
    logic [1:0]       w_dir;
    logic [3:0]       w_row_nx;
    logic [3:0]       w_col_nx;
    logic [3:0]       w_row;
    logic [3:0]       w_col;

    assign w_full = (r_count == FULL);
    assign w_pop  = (r_state == S_DRAIN) && !bus.stk_empty && !w_full;
    assign w_emit = (r_state == S_EMIT);
    assign w_dir  = r_buf[r_index];

    // Neighbour cell in the current direction with plain 4-bit wrap.
    always_comb begin
        w_row_nx = r_row;
        w_col_nx = r_col;
        case (w_dir)
            2'd0:    w_row_nx = r_row - 4'd1;
            2'd1:    w_col_nx = r_col + 4'd1;
            2'd2:    w_row_nx = r_row + 4'd1;
            default: w_col_nx = r_col - 4'd1;
        endcase
    end

`ifdef COORD_CHECK_EN
    localparam logic [7:0] DEST_RC = 8'(DEST_ADDR);

    logic w_off;

    // Flag a move that would step past the grid edge; it then holds at the edge.
    always_comb begin
        w_off = 1'b0;
        case (w_dir)
            2'd0:    w_off = (r_row == 4'd0);
            2'd1:    w_off = (r_col == 4'd15);
            2'd2:    w_off = (r_row == 4'd15);
            default: w_off = (r_col == 4'd0);
        endcase
    end

    assign w_row = w_off ? r_row : w_row_nx;
    assign w_col = w_off ? r_col : w_col_nx;
`else
    assign w_row = w_row_nx;
    assign w_col = w_col_nx;
`endif

    assign bus.stk_pop  = w_pop;
    assign bus.mv_valid = w_emit;
    assign bus.mv_dir   = w_emit ? w_dir : 2'd0;
    assign bus.mv_row   = w_emit ? w_row : 4'd0;
    assign bus.mv_col   = w_emit ? w_col : 4'd0;
    assign bus.mv_last  = w_emit && (r_index == '0);
    assign path_len     = r_path_len;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_FIN);
    assign err          = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: drain until empty or full, emit until the last handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRAIN;
            S_DRAIN: begin
                if (bus.stk_empty) w_next = (r_count == '0) ? S_FIN : S_EMIT;
                else if (w_full)   w_next = S_FIN;
            end
            S_EMIT:  if (bus.mv_ready && (r_index == '0)) w_next = S_FIN;
            default: w_next = S_IDLE;
        endcase
    end

    // Count, replay index, position and error bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_path_len <= '0;
            r_index    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count    <= '0;
                        r_path_len <= '0;
                        r_err      <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (bus.stk_empty) begin
                        // Buffer holds the path reversed; replay from the top down.
                        r_path_len <= r_count;
                        r_index    <= r_count[IDX_W-1:0] - 1'b1;
                        r_row      <= '0;
                        r_col      <= '0;
                    end else if (w_full) begin
                        r_err      <= 1'b1;
                        r_path_len <= r_count;
                    end else begin
                        r_count    <= r_count + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (bus.mv_ready) begin
                        r_row <= w_row;
                        r_col <= w_col;
                        if (r_index != '0) r_index <= r_index - 1'b1;
`ifdef COORD_CHECK_EN
                        if (w_off) r_err <= 1'b1;
`endif
                    end
                end
                default: begin
`ifdef COORD_CHECK_EN
                    if ((r_path_len != '0) && ({r_row, r_col} != DEST_RC)) r_err <= 1'b1;
`endif
                end
            endcase
        end
    end

    // Move buffer; contents are don't-care outside a drain/replay pass.
    always_ff @(posedge clk) begin
        if (w_pop) r_buf[r_count[IDX_W-1:0]] <= bus.stk_dout;
    end

endmodule

// File: tb/tb_path_replay.sv
// Testbench for path_replay: stack models feed two instances (full depth and
// MAX_LEN=4); expected moves are queued when a stack is loaded and compared
// by a negedge monitor as the DUT hands them over.
`timescale 1ns/1ps
module tb_path_replay;

`ifdef COORD_CHECK_EN
    localparam bit COORD = 1'b1;
`else
    localparam bit COORD = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] dir;
        logic [3:0] row;
        logic [3:0] col;
        logic       last;
    } mv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    always #5 clk = ~clk;

    path_replay_if bus0 ();
    path_replay_if bus1 ();

    logic [8:0] len0;
    logic       busy0, done0, err0;
    logic [2:0] len1;
    logic       busy1, done1, err1;

    path_replay #(.MAX_LEN(256), .LEN_W(9), .DEST_ADDR(255)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .bus(bus0),
        .path_len(len0), .busy(busy0), .done(done0), .err(err0)
    );

    path_replay #(.MAX_LEN(4), .LEN_W(3), .DEST_ADDR(255)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bus(bus1),
        .path_len(len1), .busy(busy1), .done(done1), .err(err1)
    );

    int checks = 0;
    int errors = 0;

    // Stack models: mem[0] is the first entry pushed, top is mem[sp-1].
    logic [1:0] mem0 [16];
    logic [1:0] mem1 [16];
    int  sp0 = 0, sp1 = 0, ld_n0 = 0, ld_n1 = 0, pops0 = 0, pops1 = 0;
    bit  ld0 = 1'b0, ld1 = 1'b0;

    assign bus0.stk_empty = (sp0 == 0);
    assign bus0.stk_dout  = (sp0 > 0) ? mem0[sp0-1] : 2'd0;
    assign bus1.stk_empty = (sp1 == 0);
    assign bus1.stk_dout  = (sp1 > 0) ? mem1[sp1-1] : 2'd0;

    always @(posedge clk) begin
        if (ld0) sp0 <= ld_n0;
        else if (bus0.stk_pop) begin sp0 <= sp0 - 1; pops0 <= pops0 + 1; end
        if (ld1) sp1 <= ld_n1;
        else if (bus1.stk_pop) begin sp1 <= sp1 - 1; pops1 <= pops1 + 1; end
    end

    // Scoreboard and monitor for the full-depth instance.
    mv_t exp_q[$];
    mv_t held, cur, e;
    bit  held_v = 1'b0;
    int  hs_cnt0 = 0;
    time last_hs_t = 0;
    bit  exp_err0 = 1'b0;

    always @(negedge clk) begin
        cur = {bus0.mv_dir, bus0.mv_row, bus0.mv_col, bus0.mv_last};
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checks++;
                if (!bus0.mv_valid || cur !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b mv=%h, required valid=1 mv=%h",
                             bus0.mv_valid, cur, held);
                end
            end
            held_v = 1'b0;
            if (bus0.mv_valid && bus0.mv_ready) begin
                hs_cnt0++;
                last_hs_t = $time;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL move_extra: got mv=%h, required no move", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL move: got dir=%0d row=%0d col=%0d last=%0b, required dir=%0d row=%0d col=%0d last=%0b",
                                 cur.dir, cur.row, cur.col, cur.last, e.dir, e.row, e.col, e.last);
                    end
                end
            end else if (bus0.mv_valid) begin
                held_v = 1'b1;
                held   = cur;
            end
        end
    end

    // Reference step: returns {off_grid, row, col}.
    function automatic logic [8:0] step(input logic [7:0] rc, input logic [1:0] d);
        int   r, c;
        logic off;
        r = int'(rc[7:4]);
        c = int'(rc[3:0]);
        case (d)
            2'd0:    r = r - 1;
            2'd1:    c = c + 1;
            2'd2:    r = r + 1;
            default: c = c - 1;
        endcase
        off = (r < 0) || (r > 15) || (c < 0) || (c > 15);
        if (COORD) begin
            if (r < 0) r = 0;
            if (r > 15) r = 15;
            if (c < 0) c = 0;
            if (c > 15) c = 15;
        end else begin
            r = r & 15;
            c = c & 15;
        end
        return {off, 4'(r), 4'(c)};
    endfunction

    function automatic logic [24:0] outs0();
        return {bus0.stk_pop, bus0.mv_valid, bus0.mv_last, done0, err0, busy0,
                bus0.mv_dir, bus0.mv_row, bus0.mv_col, len0};
    endfunction

    function automatic logic [20:0] outs1();
        return {bus1.stk_pop, bus1.mv_valid, bus1.mv_last, done1, err1, busy1,
                bus1.mv_dir, bus1.mv_row, bus1.mv_col, len1};
    endfunction

    // Fill stack 0 (dirs[1:0] pushed first) and queue the expected moves.
    task automatic load0(input logic [15:0] dirs, input int n);
        logic [7:0] rc;
        logic [8:0] s;
        logic       any_off;
        mv_t        m;
        rc = 8'h00;
        any_off = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem0[i] = dirs[2*i +: 2];
            s = step(rc, dirs[2*i +: 2]);
            any_off = any_off | s[8];
            rc = s[7:0];
            m.dir = dirs[2*i +: 2];
            m.row = rc[7:4];
            m.col = rc[3:0];
            m.last = (i == n - 1);
            exp_q.push_back(m);
        end
        exp_err0 = COORD && (any_off || ((n > 0) && (rc != 8'hFF)));
        ld_n0 = n;
        @(posedge clk); #1 ld0 = 1'b1;
        @(posedge clk); #1 ld0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.mv_ready = 1'b1;
        bus1.mv_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs0() !== '0) begin
            errors++;
            $display("FAIL reset_outs0: got %h, required 0", outs0());
        end
        checks++;
        if (outs1() !== '0) begin
            errors++;
            $display("FAIL reset_outs1: got %h, required 0", outs1());
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_replay();
        int  n, first_v, pb, hb;
        bit  got_done;
        time done_t;
        load0({8'b0, 2'd2, 2'd1, 2'd1, 2'd2}, 4);
        pb = pops0; hb = hs_cnt0;
        bus0.mv_ready = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        n = 0; first_v = -1; got_done = 1'b0; done_t = 0;
        while (!got_done && n < 100) begin
            @(negedge clk); n++;
            if (bus0.mv_valid && first_v < 0) first_v = n;
            if (done0) begin got_done = 1'b1; done_t = $time; end
        end
        checks++;
        if (!got_done) begin errors++; $display("FAIL replay_done: no done within 100 cycles"); end
        checks++;
        if (first_v != 6) begin errors++; $display("FAIL replay_latency: got %0d, required 6", first_v); end
        checks++;
        if (done_t - last_hs_t != 10) begin
            errors++; $display("FAIL replay_done_time: got %0t after last handshake, required 10", done_t - last_hs_t);
        end
        checks++;
        if (len0 !== 9'd4) begin errors++; $display("FAIL replay_len: got %0d, required 4", len0); end
        checks++;
        if (pops0 - pb != 4 || hs_cnt0 - hb != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL replay_counts: got pops=%0d hs=%0d left=%0d, required 4 4 0",
                     pops0 - pb, hs_cnt0 - hb, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0 || err0 !== exp_err0) begin
            errors++;
            $display("FAIL replay_after: got done=%0b busy=%0b err=%0b, required 0 0 %0b", done0, busy0, err0, exp_err0);
        end
    endtask

    task automatic test_empty();
        int n, first_v, pb, done_n;
        load0(16'h0, 0);
        pb = pops0;
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        n = 0; first_v = -1; done_n = -1;
        while (done_n < 0 && n < 20) begin
            @(negedge clk); n++;
            if (bus0.mv_valid && first_v < 0) first_v = n;
            if (done0) done_n = n;
        end
        checks++;
        if (done_n != 2) begin errors++; $display("FAIL empty_done: got cycle %0d, required 2", done_n); end
        checks++;
        if (pops0 != pb || first_v >= 0 || len0 !== 9'd0) begin
            errors++;
            $display("FAIL empty_path: got pops=%0d valid_at=%0d len=%0d, required 0 -1 0", pops0 - pb, first_v, len0);
        end
        @(negedge clk);
        checks++;
        if (err0 !== 1'b0) begin errors++; $display("FAIL empty_err: got %0b, required 0", err0); end
    endtask

    task automatic test_backpressure();
        int n, k, hb;
        bit got_done;
        load0({8'b0, 2'd2, 2'd1, 2'd1, 2'd2}, 4);
        hb = hs_cnt0;
        bus0.mv_ready = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        n = 0; k = 0; got_done = 1'b0;
        while (!got_done && n < 100) begin
            @(negedge clk); n++;
            if (done0) got_done = 1'b1;
            else begin
                @(posedge clk); #1;
                k++;
                bus0.mv_ready = (k % 3 == 0);
            end
        end
        bus0.mv_ready = 1'b1;
        checks++;
        if (!got_done || hs_cnt0 - hb != 4 || exp_q.size() != 0 || len0 !== 9'd4) begin
            errors++;
            $display("FAIL bp_counts: got done=%0b hs=%0d left=%0d len=%0d, required 1 4 0 4",
                     got_done, hs_cnt0 - hb, exp_q.size(), len0);
        end
    endtask

    task automatic test_back_to_back();
        int n, first_v, done_n, pb, hb;
        load0({6'b0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd1}, 5);
        pb = pops0; hb = hs_cnt0;
        bus0.mv_ready = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        n = 0; first_v = -1; done_n = -1;
        while (done_n < 0 && n < 100) begin
            @(negedge clk); n++;
            if (bus0.mv_valid && first_v < 0) first_v = n;
            if (done0) done_n = n;
            else begin
                // Stray starts while draining and while emitting must be ignored.
                @(posedge clk); #1;
                start0 = (n == 2) || (n == 8);
            end
        end
        start0 = 1'b0;
        checks++;
        if (first_v != 7 || done_n != 12) begin
            errors++; $display("FAIL b2b_timing: got valid_at=%0d done_at=%0d, required 7 12", first_v, done_n);
        end
        checks++;
        if (pops0 - pb != 5 || hs_cnt0 - hb != 5 || exp_q.size() != 0 || len0 !== 9'd5) begin
            errors++;
            $display("FAIL b2b_counts: got pops=%0d hs=%0d left=%0d len=%0d, required 5 5 0 5",
                     pops0 - pb, hs_cnt0 - hb, exp_q.size(), len0);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%0b, required 0", busy0); end
    endtask

    task automatic test_overflow();
        int n, vcnt, pb, done_n;
        mem1[0] = 2'd1; mem1[1] = 2'd2; mem1[2] = 2'd3; mem1[3] = 2'd0; mem1[4] = 2'd1;
        ld_n1 = 5;
        @(posedge clk); #1 ld1 = 1'b1;
        @(posedge clk); #1 ld1 = 1'b0;
        pb = pops1;
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        n = 0; vcnt = 0; done_n = -1;
        while (done_n < 0 && n < 40) begin
            @(negedge clk); n++;
            if (bus1.mv_valid) vcnt++;
            if (done1) done_n = n;
        end
        checks++;
        if (done_n != 6) begin errors++; $display("FAIL ovf_done: got cycle %0d, required 6", done_n); end
        checks++;
        if (pops1 - pb != 4 || vcnt != 0 || bus1.stk_empty !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pops: got pops=%0d valid_cycles=%0d empty=%0b, required 4 0 0",
                     pops1 - pb, vcnt, bus1.stk_empty);
        end
        checks++;
        if (err1 !== 1'b1 || len1 !== 3'd4) begin
            errors++; $display("FAIL ovf_err_len: got err=%0b len=%0d, required 1 4", err1, len1);
        end
        // A fresh start clears the sticky error on the first drain cycle.
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        @(negedge clk);
        checks++;
        if (err1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++; $display("FAIL ovf_clear: got err=%0b busy=%0b, required 0 1", err1, busy1);
        end
        repeat (8) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int n, hb;
        bit got_done;
        load0({8'b0, 2'd2, 2'd1, 2'd1, 2'd2}, 4);
        hb = hs_cnt0;
        bus0.mv_ready = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        n = 0;
        while (hs_cnt0 - hb < 2 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        rst = 1'b1;
        bus0.mv_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (n >= 50 || outs0() !== '0) begin
            errors++; $display("FAIL rst_mid_outs: got %h (wait=%0d), required 0", outs0(), n);
        end
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        load0({8'b0, 2'd2, 2'd1, 2'd1, 2'd2}, 4);
        hb = hs_cnt0;
        bus0.mv_ready = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        n = 0; got_done = 1'b0;
        while (!got_done && n < 100) begin
            @(negedge clk); n++;
            if (done0) got_done = 1'b1;
        end
        checks++;
        if (!got_done || hs_cnt0 - hb != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_replay: got done=%0b hs=%0d left=%0d, required 1 4 0",
                     got_done, hs_cnt0 - hb, exp_q.size());
        end
    endtask

    task automatic test_coord();
        int  n;
        bit  got_done, seen;
        logic [3:0] row_req;
        row_req = COORD ? 4'd0 : 4'd15;
        load0({14'b0, 2'd0}, 1);
        bus0.mv_ready = 1'b0;
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            if (bus0.mv_valid) seen = 1'b1;
        end
        checks++;
        if (!seen || bus0.mv_row !== row_req || bus0.mv_col !== 4'd0) begin
            errors++;
            $display("FAIL coord_row: got valid=%0b row=%0d col=%0d, required 1 %0d 0",
                     seen, bus0.mv_row, bus0.mv_col, row_req);
        end
        @(posedge clk); #1 bus0.mv_ready = 1'b1;
        n = 0; got_done = 1'b0;
        while (!got_done && n < 20) begin
            @(negedge clk); n++;
            if (done0) got_done = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (!got_done || err0 !== COORD) begin
            errors++; $display("FAIL coord_err: got done=%0b err=%0b, required 1 %0b", got_done, err0, COORD);
        end
    endtask

    initial begin
        bus0.mv_ready = 1'b1;
        bus1.mv_ready = 1'b1;
        test_reset();
        test_replay();
        test_empty();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_coord();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
